// File: rtl/unidade_de_controle.sv
// unidade_de_controle: multi-cycle MIPS control FSM; fetches, decodes into a class,
// sequences execute/memory/writeback and owns the PC.
module unidade_de_controle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        uc_in_clk,
  input  logic        uc_in_rst,
  output logic        uc_out_imem_req,
  input  logic        uc_in_imem_ack,
  input  logic [31:0] uc_in_instr,
  output logic [31:0] uc_out_pc,
  input  logic        uc_in_alu_zero,
  output logic        uc_out_dmem_req,
  output logic        uc_out_dmem_we,
  input  logic        uc_in_dmem_ack,
  output logic [2:0]  uc_out_FSM,
  output logic [7:0]  uc_out_FSM2,
  output logic [4:0]  uc_out_rs,
  output logic [4:0]  uc_out_rt,
  output logic [4:0]  uc_out_rd,
  output logic        uc_out_alu_src_imm,
  output logic [1:0]  uc_out_wb_sel,
  output logic        uc_out_halt
);
  typedef enum logic [2:0] {
    S_RESET   = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_EXECUTE = 3'b011,
    S_MEM     = 3'b100,
    S_WB      = 3'b110,
    S_HALT    = 3'b111
  } state_t;
  state_t      r_state;
  logic [31:0] r_ir;
  logic [31:0] r_pc;
  logic [7:0]  r_class;
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic        w_syscall;
  logic [7:0]  w_class;
  logic        w_taken;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  assign w_op        = r_ir[31:26];
  assign w_funct     = r_ir[5:0];
  assign w_syscall   = (w_op == 6'h00) && (w_funct == 6'h0C);
  assign w_taken     = ((w_op == 6'h04) && uc_in_alu_zero) || ((w_op == 6'h05) && !uc_in_alu_zero);
  assign w_br_target = r_pc + {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
  assign w_j_target  = {r_pc[31:28], r_ir[25:0], 2'b00};
  always_comb begin
    w_class = (w_op == 6'h00) ? (w_syscall ? 8'd0 : 8'd1) :
              (w_op == 6'h08 || w_op == 6'h0A || w_op == 6'h0C || w_op == 6'h0D) ? 8'd2 :
              (w_op == 6'h23) ? 8'd3 :
              (w_op == 6'h2B) ? 8'd4 :
              (w_op == 6'h04 || w_op == 6'h05) ? 8'd5 :
              (w_op == 6'h03) ? 8'd6 :
              (w_op == 6'h02) ? 8'd7 : 8'd0;
  end
  always_ff @(posedge uc_in_clk) begin
    if (uc_in_rst) begin
      r_state <= S_RESET;
      r_ir    <= 32'h0;
      r_pc    <= RESET_PC;
      r_class <= 8'd0;
    end else begin
      case (r_state)
        S_RESET: r_state <= S_FETCH;
        S_FETCH: if (uc_in_imem_ack) begin
          r_ir    <= uc_in_instr;
          r_pc    <= r_pc + 32'd4;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_class <= w_class;
          r_state <= w_syscall ? S_HALT : (w_class == 8'd0) ? S_FETCH : S_EXECUTE;
        end
        S_EXECUTE: begin
          if (r_class == 8'd5 && w_taken) r_pc <= w_br_target;
          if (r_class == 8'd7) r_pc <= w_j_target;
          r_state <= (r_class == 8'd3 || r_class == 8'd4) ? S_MEM :
                     (r_class == 8'd1 || r_class == 8'd2 || r_class == 8'd6) ? S_WB : S_FETCH;
        end
        S_MEM: if (uc_in_dmem_ack) r_state <= (r_class == 8'd3) ? S_WB : S_FETCH;
        S_WB: begin
          // jal keeps PC+4 visible during writeback so the link value can be written
          if (r_class == 8'd6) r_pc <= w_j_target;
          r_state <= S_FETCH;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_RESET;
      endcase
    end
  end
  assign uc_out_FSM         = r_state;
  assign uc_out_FSM2        = r_class;
  assign uc_out_pc          = r_pc;
  assign uc_out_imem_req    = (r_state == S_FETCH);
  assign uc_out_dmem_req    = (r_state == S_MEM);
  assign uc_out_dmem_we     = (r_state == S_MEM) && (r_class == 8'd4);
  assign uc_out_halt        = (r_state == S_HALT);
  assign uc_out_rs          = r_ir[25:21];
  assign uc_out_rt          = r_ir[20:16];
  assign uc_out_alu_src_imm = (r_class == 8'd2) || (r_class == 8'd3) || (r_class == 8'd4);
  assign uc_out_wb_sel      = (r_class == 8'd3) ? 2'b01 : (r_class == 8'd6) ? 2'b10 : 2'b00;
  always_comb begin
    uc_out_rd = (r_class == 8'd1) ? r_ir[15:11] :
                (r_class == 8'd2 || r_class == 8'd3) ? r_ir[20:16] :
                (r_class == 8'd6) ? 5'd31 : 5'd0;
  end
endmodule

// File: tb/tb_unidade_de_controle.sv
// tb_unidade_de_controle: randomized bench comparing the control FSM against an
// instruction-level model that predicts each cycle's state and outputs.
module tb_unidade_de_controle;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic        clk = 0;
  logic        rst = 1;
  logic        imem_ack = 0;
  logic        dmem_ack = 0;
  logic        alu_zero = 0;
  logic [31:0] instr = 0;
  logic        imem_req, dmem_req, dmem_we, alu_src_imm, halt;
  logic [31:0] pc;
  logic [2:0]  fsm;
  logic [7:0]  fsm2;
  logic [4:0]  rs, rt, rd;
  logic [1:0]  wb_sel;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;

  unidade_de_controle #(.RESET_PC(RESET_PC)) dut (
    .uc_in_clk(clk), .uc_in_rst(rst),
    .uc_out_imem_req(imem_req), .uc_in_imem_ack(imem_ack), .uc_in_instr(instr),
    .uc_out_pc(pc), .uc_in_alu_zero(alu_zero),
    .uc_out_dmem_req(dmem_req), .uc_out_dmem_we(dmem_we), .uc_in_dmem_ack(dmem_ack),
    .uc_out_FSM(fsm), .uc_out_FSM2(fsm2),
    .uc_out_rs(rs), .uc_out_rt(rt), .uc_out_rd(rd),
    .uc_out_alu_src_imm(alu_src_imm), .uc_out_wb_sel(wb_sel), .uc_out_halt(halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // class per the instruction table; -1 marks syscall
  function automatic int cls_of(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'h00) return (ins[5:0] == 6'h0C) ? -1 : 1;
    if (op == 6'h08 || op == 6'h0A || op == 6'h0C || op == 6'h0D) return 2;
    if (op == 6'h23) return 3;
    if (op == 6'h2B) return 4;
    if (op == 6'h04 || op == 6'h05) return 5;
    if (op == 6'h03) return 6;
    if (op == 6'h02) return 7;
    return 0;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  ops_i [4];
    logic [5:0]  ops_n [4];
    int          k;
    ops_i = '{6'h08, 6'h0A, 6'h0C, 6'h0D};
    ops_n = '{6'h01, 6'h06, 6'h3F, 6'h10};
    r = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: r[31:26] = 6'h00;
      1: r[31:26] = ops_i[$urandom_range(0, 3)];
      2: r[31:26] = 6'h23;
      3: r[31:26] = 6'h2B;
      4: r[31:26] = 6'h04;
      5: r[31:26] = 6'h05;
      6: r[31:26] = 6'h03;
      7: r[31:26] = 6'h02;
      8: r[31:26] = ops_n[$urandom_range(0, 3)];
      default: ;
    endcase
    if (r[31:26] == 6'h00 && r[5:0] == 6'h0C) r[5:0] = 6'h20;
    return r;
  endfunction

  task automatic do_reset(input int n);
    rst = 1;
    imem_ack = 0;
    dmem_ack = 0;
    repeat (n) tick();
    chk("rst_fsm", fsm, 3'b000);
    chk("rst_fsm2", fsm2, 8'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_regs", {rs, rt, rd}, 15'd0);
    chk("rst_imm", alu_src_imm, 1'b0);
    chk("rst_wb_sel", wb_sel, 2'b00);
    chk("rst_halt", halt, 1'b0);
    rst = 0;
    tick();
    chk("rel_fsm", fsm, 3'b001);
    chk("rel_imem_req", imem_req, 1'b1);
    chk("rel_pc", pc, RESET_PC);
    m_pc = RESET_PC;
  endtask

  // expected cycle-by-cycle state list for one instruction, then walk it
  task automatic exec(input logic [31:0] ins, input int iw, input int dw, input logic z);
    logic [2:0] q[$];
    int         c;
    int         mem_i;
    logic [4:0] e_rd;
    logic [1:0] e_wb;
    logic       taken;
    c = cls_of(ins);
    e_rd = (c == 1) ? ins[15:11] : (c == 2 || c == 3) ? ins[20:16] : (c == 6) ? 5'd31 : 5'd0;
    e_wb = (c == 3) ? 2'b01 : (c == 6) ? 2'b10 : 2'b00;
    taken = (ins[31:26] == 6'h04 && z) || (ins[31:26] == 6'h05 && !z);
    for (int i = 0; i <= iw; i++) q.push_back(3'b001);
    q.push_back(3'b010);
    if (c > 0) q.push_back(3'b011);
    if (c == 3 || c == 4) for (int i = 0; i <= dw; i++) q.push_back(3'b100);
    if (c == 1 || c == 2 || c == 3 || c == 6) q.push_back(3'b110);
    alu_zero = z;
    mem_i = 0;
    for (int i = 0; i < q.size(); i++) begin
      chk("state", fsm, q[i]);
      imem_ack = 1'($urandom_range(0, 1));
      dmem_ack = 1'($urandom_range(0, 1));
      instr = $urandom;
      if (q[i] == 3'b001) begin
        chk("imem_req", imem_req, 1'b1);
        chk("fetch_pc", pc, m_pc);
        chk("dmem_idle", dmem_req, 1'b0);
        imem_ack = (i == iw);
        if (i == iw) instr = ins;
      end else if (q[i] == 3'b010) begin
        chk("dec_imem_req", imem_req, 1'b0);
      end else if (q[i] == 3'b011) begin
        chk("fsm2", fsm2, c);
        chk("rs", rs, ins[25:21]);
        chk("rt", rt, ins[20:16]);
        chk("rd", rd, e_rd);
        chk("alu_src_imm", alu_src_imm, (c == 2 || c == 3 || c == 4));
        chk("ex_reqs", {imem_req, dmem_req}, 2'b00);
      end else if (q[i] == 3'b100) begin
        chk("dmem_req", dmem_req, 1'b1);
        chk("dmem_we", dmem_we, (c == 4));
        dmem_ack = (mem_i == dw);
        mem_i++;
      end else begin
        chk("wb_sel", wb_sel, e_wb);
        chk("wb_rd", rd, e_rd);
        chk("wb_pc", pc, m_pc);
      end
      tick();
      if (q[i] == 3'b001 && i == iw) m_pc = m_pc + 32'd4;
    end
    imem_ack = 0;
    dmem_ack = 0;
    if (c == 5 && taken) m_pc = m_pc + {{14{ins[15]}}, ins[15:0], 2'b00};
    if (c == 6 || c == 7) m_pc = {m_pc[31:28], ins[25:0], 2'b00};
  endtask

  initial begin
    do_reset(3);
    exec(32'h01285020, 0, 0, 1'b0);
    exec(32'h8FA80008, 0, 3, 1'b0);
    exec(32'h08000004, 0, 0, 1'b0);
    exec(32'h1000FFFF, 0, 0, 1'b1);
    exec(32'h1000FFFF, 1, 0, 1'b0);
    exec(32'h08000008, 0, 0, 1'b0);
    exec(32'h0C000040, 0, 0, 1'b0);
    exec(32'hAFA80004, 2, 1, 1'b0);
    for (int n = 0; n < 300; n++)
      exec(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    rst = 1;
    imem_ack = 0;
    tick();
    chk("midrst_fsm", fsm, 3'b000);
    chk("midrst_imem_req", imem_req, 1'b0);
    chk("midrst_pc", pc, RESET_PC);
    do_reset(2);
    exec(32'h01285020, 1, 0, 1'b0);
    exec(32'h0000000C, 1, 0, 1'b0);
    for (int n = 0; n < 6; n++) begin
      imem_ack = 1'($urandom_range(0, 1));
      dmem_ack = 1'($urandom_range(0, 1));
      chk("halt_fsm", fsm, 3'b111);
      chk("halt", halt, 1'b1);
      chk("halt_reqs", {imem_req, dmem_req}, 2'b00);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
